latency_mem_window: RTL
=======================

Name: latency_mem_window

Overview:
- Parametrised successor to the flat word memory model used by the CHIP benches.
- Maps a WORD_DEPTH-word array at a runtime base address (offset).
- Adds a valid/ready request handshake, a configurable response latency, byte-lane write enables, and misalignment/miss reporting.
- Several instances share one data bus (e.g. data and stack windows); only the instance whose window is hit responds.

Parameters:
- DATA_W, 32, data width in bits (multiple of 8).
- ADDR_W, 32, byte-address width.
- WORD_DEPTH, 60, number of words in the window.
- LATENCY, 1, cycles from request acceptance to rsp_valid (legal 1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- offset  in  ADDR_W  byte base address of the window; must be word-aligned and held stable while busy.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables.
- rsp_valid  out  1  one-cycle response strobe (hit requests only).
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  pulses with rsp_valid when the request was misaligned.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, latency counter 0. Array contents are not cleared by reset; the bench preloads them.
- Decode: idx = (req_addr - offset) >> log2(DATA_W/8). The request is a hit when req_addr >= offset and idx < WORD_DEPTH, using unsigned ADDR_W arithmetic. The subtraction must not wrap into a false hit.
- Misaligned means the low address bits are nonzero. A misaligned hit performs no write and returns rdata=0 with rsp_err=1.
- Acceptance: a request is accepted on a rising edge with req_valid & req_ready.
  - Miss: ignored completely. No state change, no response, req_ready stays 1.
- Write commit: at the acceptance edge, only lanes with req_be set are written. be=0 is a legal no-op that still responds.
- Read capture: the word is captured at the acceptance edge, with old-data semantics. It is held in a response register until the response.
- FSM:
  - IDLE: req_ready=1. Hit accepted -> BUSY with cnt=LATENCY-1.
  - BUSY: req_ready=0. cnt decrements each cycle. cnt==0 -> RESP. If LATENCY=1, the path is IDLE -> RESP directly.
  - RESP: rsp_valid=1, rsp_rdata/rsp_err driven for exactly one cycle, req_ready=1.
    - A hit accepted in RESP starts the next transaction (back-to-back) -> BUSY or RESP.
    - Otherwise -> IDLE.
- Response timing: rsp_valid rises exactly LATENCY cycles after the acceptance edge. Throughput is one request per LATENCY cycles.
- Single outstanding request. Requests presented while req_ready=0 are not accepted; the requester holds them.
- Outside RESP: rsp_rdata and rsp_err are 0, which allows OR-combining instances on a shared bus.
- Reset mid-operation: the pending response is dropped and outputs return to their reset values. A write already committed at acceptance is not reverted.
- offset change while BUSY: undefined; the bench never does it.

Decomposition:
- latency_mem_pkg:
  - state enum {IDLE, BUSY, RESP}.
  - BYTES = DATA_W/8.
  - function for index computation.
  - LAT_CNT_W = 3.
- One sub-module, lm_word_array: WORD_DEPTH x DATA_W storage with byte-lane write and synchronous read capture. It exposes mem[] hierarchically for bench preload and checking.

Test Plan:
- Reset, offset=0x0001_0000, LATENCY=1; read 0x0001_0008 with preload word2=0xDEAD_BEEF -> rsp_valid one cycle after acceptance, rdata=0xDEAD_BEEF, err=0.
- LATENCY=3; write 0x1234_5678 to 0x0001_0004 with be=4'b0101 over preload 0xFFFF_FFFF -> mem[1]=0xFF34_FF78. req_ready is low for 2 cycles, and rsp_valid rises 3 cycles after acceptance.
- Two instances at offsets 0x0001_0100 and 0xBFFF_FF04; a read of 0xBFFF_FF08 -> only the second asserts rsp_valid. A read of 0x0000_0000 -> neither responds, and req_ready stays 1 on both.
- Boundaries: address offset+4*(WORD_DEPTH-1) -> hit. Address offset+4*WORD_DEPTH and address offset-4 -> miss. Misaligned 0x0001_0002 write -> rsp_err=1, memory unchanged.
- Back-to-back: LATENCY=2, two reads held valid -> second accepted in the RESP cycle of the first, and the responses are 2 cycles apart.
- Assert rst in the BUSY cycle of a write -> rsp_valid never pulses, req_ready=1 after reset, and the written word is retained.

Source files
------------

// File: rtl/latency_mem_pkg.sv
// latency_mem_pkg: shared types, constants and address decode helper for latency_mem_window
package latency_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int BYTES = DATA_W_DEF / 8;
  localparam int LAT_CNT_W = 3;
  function automatic logic [63:0] word_index(input logic [63:0] diff, input int shift);
    return diff >> shift;
  endfunction
endpackage

// File: rtl/lm_word_array.sv
// lm_word_array: word storage with byte-lane writes and old-data read capture
module lm_word_array
  import latency_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORD_DEPTH = 60,
  parameter int IW = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [IW-1:0]       idx,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [WORD_DEPTH];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[idx];
    for (int b = 0; b < DATA_W / 8; b++)
      if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
endmodule

// File: rtl/latency_mem_window.sv
// latency_mem_window: offset-mapped word memory with valid/ready requests and fixed response latency
module latency_mem_window
  import latency_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int WORD_DEPTH = 60,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   offset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int NB = DATA_W / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = $clog2(WORD_DEPTH);
  state_t state;
  logic [LAT_CNT_W-1:0] cnt;
  logic err_q, wen_q, hit, mis, acc;
  logic [ADDR_W-1:0] diff, idx;
  logic [DATA_W-1:0] q;
  assign diff = req_addr - offset;
  assign idx = ADDR_W'(word_index(64'(diff), SH));
  // the >= guard stops addresses below the window from wrapping into a hit
  assign hit = (req_addr >= offset) && (idx < ADDR_W'(WORD_DEPTH));
  assign mis = |req_addr[SH-1:0];
  assign req_ready = state != BUSY;
  assign acc = req_valid && req_ready && hit;
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !wen_q) ? q : '0;
  lm_word_array #(.DATA_W(DATA_W), .WORD_DEPTH(WORD_DEPTH), .IW(IW)) u_arr (
    .clk(clk),
    .we(acc && req_wen && !mis),
    .re(acc && !req_wen && !mis),
    .idx(idx[IW-1:0]),
    .be(req_be),
    .wdata(req_wdata),
    .rdata(q)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      err_q <= 1'b0;
      wen_q <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      state <= (cnt == LAT_CNT_W'(1)) ? RESP : BUSY;
    end else if (acc) begin
      state <= (LATENCY == 1) ? RESP : BUSY;
      cnt <= LAT_CNT_W'(LATENCY - 1);
      err_q <= mis;
      wen_q <= req_wen;
    end else begin
      state <= IDLE;
    end
  end
endmodule
